wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back end of the MEM/WB pipeline latch in the 8-bit pipelined core.
//   Consumes the latched ALU result, memory data and MemToReg select, and picks
//   the write-back value. It commits that value into an 8-entry register file
//   and serves two decode-stage read ports with same-cycle write-through bypass.
//   It also keeps a one-cycle forwarding copy of the last write and a retired-
//   instruction counter.
// PARAMETERS
//   DATA_W   8    register/data width
//   ADDR_W   3    register address width (2**ADDR_W registers, r0 hardwired 0)
//   CNT_W    16   retired-instruction counter width
// PORTS
//   clk2         in   1        core clock, all state updates on posedge
//   rst_n        in   1        asynchronous reset, active-low
//   alu_in       in   DATA_W   ALU result from MEM/WB latch
//   mem_in       in   DATA_W   memory read data from MEM/WB latch
//   MemToRegmux  in   1        1: write mem_in, 0: write alu_in
//   wb_valid     in   1        a real instruction occupies WB this cycle
//   wb_regwrite  in   1        instruction writes a register
//   wb_rd        in   ADDR_W   destination register
//   rs1_addr     in   ADDR_W   decode read port 1 address
//   rs2_addr     in   ADDR_W   decode read port 2 address
//   cnt_clr      in   1        synchronous clear of retire_cnt
//   rs1_data     out  DATA_W   read port 1 data (combinational)
//   rs2_data     out  DATA_W   read port 2 data (combinational)
//   wb_data      out  DATA_W   selected write-back value (combinational)
//   fwd_valid    out  1        registered: previous cycle committed a write
//   fwd_rd       out  ADDR_W   registered destination of that write
//   fwd_data     out  DATA_W   registered data of that write
//   retire_cnt   out  CNT_W    count of retired instructions
// BEHAVIOUR
//   - Reset state (rst_n low, async): all registers 0; fwd_valid/fwd_rd/fwd_data
//     are 0; retire_cnt is 0. No write happens while rst_n is low. A reset
//     asserted mid-stream discards any write on that edge.
//   - wb_data = MemToRegmux ? mem_in : alu_in. It is valid whenever the inputs
//     are valid. MemToRegmux is don't-care when wb_valid=0.
//   - commit = wb_valid & wb_regwrite & (wb_rd != 0).
//   - On posedge clk2, if commit: rf[wb_rd] <= wb_data. Write latency is 1 edge.
//   - r0 always reads 0. Writes to r0 are dropped; they do not set fwd_valid
//     but do count as retired.
//   - Read ports are combinational. If commit and rsN_addr == wb_rd, then
//     rsN_data = wb_data in the same cycle (bypass). Otherwise rsN_data =
//     rf[rsN_addr]. Both ports may hit the bypass together.
//   - Forwarding register, every posedge:
//     - fwd_valid <= commit.
//     - fwd_rd/fwd_data load wb_rd/wb_data only when commit, else hold.
//   - Retire counter, every posedge, with cnt_clr taking priority:
//     - cnt_clr: retire_cnt <= 0, even if wb_valid.
//     - else wb_valid: increment by 1, saturating at 2**CNT_W-1 with no wrap.
//     - else hold.
//   - Back-to-back writes to the same rd: the last edge wins. The bypass always
//     reflects the current cycle's commit, never stale data.
//   - No handshake. WB never stalls; every valid input is consumed in 1 cycle.
// TESTING
//   1 Reset: rst_n=0 mid-run after writes -> rs1_data(r3)=0, fwd_valid=0,
//     retire_cnt=0 immediately, before any clock edge.
//   2 Mux+write: alu_in=8'h5A, mem_in=8'hC3, MemToRegmux=1, rd=2, valid,
//     regwrite -> wb_data=C3. After the edge, rs1_addr=2 reads C3 and
//     fwd_valid=1, fwd_rd=2, fwd_data=C3. Repeat with sel=0 -> 5A.
//   3 Bypass: commit rd=5 data=8'h77 with rs1_addr=rs2_addr=5 in the same
//     cycle -> both ports read 77 before the edge. Repeat with wb_valid=0 ->
//     ports read the old rf[5].
//   4 r0: commit rd=0 data=FF -> rs1_data(r0)=0, fwd_valid=0 next cycle,
//     retire_cnt increments.
//   5 Counter: preload near 16'hFFFE with 3 valid cycles -> FFFF held.
//     cnt_clr together with wb_valid -> 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back bus bundle: MEM/WB latch fields in, decode read ports and
// forwarding/retire status out. Combinational read ports; no flow control.
// Ports: master drives the WB latch fields, addresses and cnt_clr; slave
// (the register file) drives read data, wb_data, forwarding and retire_cnt.
interface wb_regfile_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] alu_in;
   logic [DATA_W-1:0] mem_in;
   logic              MemToRegmux;
   logic              wb_valid;
   logic              wb_regwrite;
   logic [ADDR_W-1:0] wb_rd;
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic              cnt_clr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [DATA_W-1:0] wb_data;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output alu_in, mem_in, MemToRegmux, wb_valid, wb_regwrite, wb_rd,
             rs1_addr, rs2_addr, cnt_clr,
      input  rs1_data, rs2_data, wb_data, fwd_valid, fwd_rd, fwd_data,
             retire_cnt
   );

   modport slave (
      input  alu_in, mem_in, MemToRegmux, wb_valid, wb_regwrite, wb_rd,
             rs1_addr, rs2_addr, cnt_clr,
      output rs1_data, rs2_data, wb_data, fwd_valid, fwd_rd, fwd_data,
             retire_cnt
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects ALU/memory result, commits it to an 8-entry
// register file (r0 = 0), with same-cycle read bypass, a one-cycle forwarding
// copy of the last write and a saturating retired-instruction counter.
// Latency: write visible in rf 1 edge later, bypass 0 cycles. Never stalls.
// Ports: clk2 core clock, rst_n async active-low reset, bus (slave modport)
// carries the WB latch fields, read ports, forwarding and retire count.
// The interface parameters must match this module's parameters.
module wb_regfile #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic        clk2,
   input  logic        rst_n,
   wb_regfile_if.slave bus
);
   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] wb_data;
   logic              commit;

   logic              fwd_valid_q, fwd_valid_d;
   logic [ADDR_W-1:0] fwd_rd_q,    fwd_rd_d;
   logic [DATA_W-1:0] fwd_data_q,  fwd_data_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

   assign wb_data = bus.MemToRegmux ? bus.mem_in : bus.alu_in;
   // r0 is never written, so rf_q[0] stays at its reset value of 0.
   assign commit  = bus.wb_valid & bus.wb_regwrite & (bus.wb_rd != '0);

   // Register file: entry 0 is excluded by commit.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (commit) begin
         rf_q[bus.wb_rd] <= wb_data;
      end
   end

   // Read ports: the explicit r0 check keeps r0 at zero regardless of bypass.
   always_comb begin
      bus.rs1_data = rf_q[bus.rs1_addr];
      bus.rs2_data = rf_q[bus.rs2_addr];
      if (commit && bus.rs1_addr == bus.wb_rd) bus.rs1_data = wb_data;
      if (commit && bus.rs2_addr == bus.wb_rd) bus.rs2_data = wb_data;
      if (bus.rs1_addr == '0) bus.rs1_data = '0;
      if (bus.rs2_addr == '0) bus.rs2_data = '0;
   end

   // Forwarding copy: valid pulses for one cycle, payload holds otherwise.
   always_comb begin
      fwd_valid_d = commit;
      fwd_rd_d    = fwd_rd_q;
      fwd_data_d  = fwd_data_q;
      if (commit) begin
         fwd_rd_d   = bus.wb_rd;
         fwd_data_d = wb_data;
      end
   end

   // Retire counter: clear wins over increment; saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr)                         cnt_d = '0;
      else if (bus.wb_valid && cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         fwd_valid_q <= 1'b0;
         fwd_rd_q    <= '0;
         fwd_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         fwd_valid_q <= fwd_valid_d;
         fwd_rd_q    <= fwd_rd_d;
         fwd_data_q  <= fwd_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.wb_data    = wb_data;
   assign bus.fwd_valid  = fwd_valid_q;
   assign bus.fwd_rd     = fwd_rd_q;
   assign bus.fwd_data   = fwd_data_q;
   assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: vector table with per-cycle scoreboard of the
// registered outputs, plus hand sequences for reset and counter saturation.
module tb_wb_regfile;
   logic clk2 = 1'b0;
   logic rst_n;

   always #5 clk2 = ~clk2;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk2  (clk2),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] alu;
      logic [7:0] mem;
      logic       sel;
      logic       vld;
      logic       rw;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [7:0] exp_wb;
      logic [7:0] exp_rs1;
      logic [7:0] exp_rs2;
   } vec_t;

   typedef struct {
      logic        vld;
      logic [2:0]  rd;
      logic [7:0]  data;
      logic [15:0] cnt;
   } sb_t;

   sb_t sb_q[$];

   int tests = 0;
   int fails = 0;

   logic [2:0]  m_rd   = '0;
   logic [7:0]  m_data = '0;
   logic [15:0] m_cnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] alu, input logic [7:0] mem, input logic sel,
                        input logic vld, input logic rw, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic clr);
      bus.alu_in      = alu;
      bus.mem_in      = mem;
      bus.MemToRegmux = sel;
      bus.wb_valid    = vld;
      bus.wb_regwrite = rw;
      bus.wb_rd       = rd;
      bus.rs1_addr    = rs1;
      bus.rs2_addr    = rs2;
      bus.cnt_clr     = clr;
   endtask

   // Called just after a negedge; leaves time just after the next negedge.
   task automatic apply(input vec_t v, input int idx);
      sb_t e;
      sb_t g;
      drive(v.alu, v.mem, v.sel, v.vld, v.rw, v.rd, v.rs1, v.rs2, 1'b0);
      #2;
      chk($sformatf("wb_data[%0d]", idx), bus.wb_data, v.exp_wb);
      chk($sformatf("rs1_data[%0d]", idx), bus.rs1_data, v.exp_rs1);
      chk($sformatf("rs2_data[%0d]", idx), bus.rs2_data, v.exp_rs2);
      // Reference model of the registered side effects of this cycle.
      if (v.vld && v.rw && v.rd != 3'd0) begin
         m_rd   = v.rd;
         m_data = v.exp_wb;
         e.vld  = 1'b1;
      end else begin
         e.vld  = 1'b0;
      end
      if (v.vld && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      e.rd   = m_rd;
      e.data = m_data;
      e.cnt  = m_cnt;
      sb_q.push_back(e);
      @(posedge clk2);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         g = sb_q.pop_front();
         chk($sformatf("fwd_valid[%0d]", idx), bus.fwd_valid, g.vld);
         chk($sformatf("fwd_rd[%0d]", idx), bus.fwd_rd, g.rd);
         chk($sformatf("fwd_data[%0d]", idx), bus.fwd_data, g.data);
         chk($sformatf("retire_cnt[%0d]", idx), bus.retire_cnt, g.cnt);
      end
      @(negedge clk2);
   endtask

   vec_t vecs[9];

   initial begin
      //            alu    mem    sel   vld   rw    rd    rs1   rs2   wb     rs1    rs2
      vecs[0] = '{8'h5A, 8'hC3, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 3'd0, 8'hC3, 8'hC3, 8'h00};
      vecs[1] = '{8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1, 3'd3, 3'd2, 3'd3, 8'h5A, 8'hC3, 8'h5A};
      vecs[2] = '{8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 3'd4, 3'd3, 3'd4, 8'h11, 8'h5A, 8'h00};
      vecs[3] = '{8'h77, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 8'h77, 8'h77, 8'h77};
      vecs[4] = '{8'h99, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 3'd5, 8'h99, 8'h77, 8'h77};
      vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 8'hFF, 8'h00, 8'hC3};
      vecs[6] = '{8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 3'd6, 8'h10, 8'h10, 8'h10};
      vecs[7] = '{8'h20, 8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 3'd5, 8'h20, 8'h20, 8'h77};
      vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 3'd3, 8'h00, 8'h20, 8'h5A};

      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 1'b0);
      rst_n = 1'b0;
      #12;
      chk("reset_fwd_valid", bus.fwd_valid, 1'b0);
      chk("reset_retire_cnt", bus.retire_cnt, 16'd0);
      chk("reset_rs1_r3", bus.rs1_data, 8'h00);
      @(negedge clk2);
      rst_n = 1'b1;
      @(negedge clk2);

      for (int i = 0; i < 9; i++) apply(vecs[i], i);

      // Mid-run async reset: commit r1 so fwd_valid is high, then reset between edges.
      drive(8'h3C, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 3'd3, 3'd1, 1'b0);
      @(posedge clk2);
      #1;
      chk("pre_rst_fwd_valid", bus.fwd_valid, 1'b1);
      chk("pre_rst_cnt", bus.retire_cnt, m_cnt + 16'd1);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd1, 1'b0);
      #1;
      chk("pre_rst_rs1_r3", bus.rs1_data, 8'h5A);
      chk("pre_rst_rs2_r1", bus.rs2_data, 8'h3C);
      rst_n = 1'b0;
      #1;
      chk("rst_rs1_r3", bus.rs1_data, 8'h00);
      chk("rst_fwd_valid", bus.fwd_valid, 1'b0);
      chk("rst_retire_cnt", bus.retire_cnt, 16'd0);
      // Write attempted across an edge while in reset must be dropped.
      @(negedge clk2);
      drive(8'hAA, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 3'd1, 1'b0);
      @(posedge clk2);
      #1;
      chk("rst_hold_fwd_valid", bus.fwd_valid, 1'b0);
      @(negedge clk2);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd1, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_drop_r3", bus.rs1_data, 8'h00);
      chk("rst_clear_r1", bus.rs2_data, 8'h00);
      chk("rst_drop_cnt", bus.retire_cnt, 16'd0);
      @(negedge clk2);

      // Counter saturation: count valid non-writing cycles up to FFFE, then 3 more.
      drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      repeat (65534) @(posedge clk2);
      #1;
      chk("cnt_fffe", bus.retire_cnt, 16'hFFFE);
      repeat (3) @(posedge clk2);
      #1;
      chk("cnt_sat", bus.retire_cnt, 16'hFFFF);
      chk("cnt_sat_no_fwd", bus.fwd_valid, 1'b0);
      @(negedge clk2);
      bus.cnt_clr = 1'b1;
      @(posedge clk2);
      #1;
      chk("cnt_clr_with_valid", bus.retire_cnt, 16'd0);
      @(negedge clk2);
      bus.cnt_clr = 1'b0;
      @(posedge clk2);
      #1;
      chk("cnt_after_clr", bus.retire_cnt, 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
